pixel_packer: RTL and testbench

- Upstream neighbour of the stream output stage: converts a one-pixel-per-beat 24-bit RGB stream into a 32-bit AXI-Stream video stream.
- Four pixels are packed into three words, so one line is X_PIXELS*3/4 words.
- Generates tuser on the first word of each frame and tlast on the last word of each line.
- Resynchronises the frame position on an upstream start-of-frame marker.

---
 rtl/pixel_packer.sv | 190 +++++++++++++++++++
 tb/tb_pixel_packer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
// Packs a one-pixel-per-beat 24-bit RGB stream into 32-bit AXI-Stream words,
// four pixels to three words, with frame/line flags and start-of-frame resync.
module pixel_packer #(
    parameter int X_PIXELS = 256,
    parameter int Y_LINES  = 256
) (
    input  logic        out_stream_aclk,
    input  logic        periph_resetn,
    input  logic [23:0] in_pixel,
    input  logic        in_sof,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        sync_err
);

    localparam int XW = (X_PIXELS > 1) ? $clog2(X_PIXELS) : 1;
    localparam int YW = (Y_LINES > 1) ? $clog2(Y_LINES) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(X_PIXELS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(Y_LINES - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);

    typedef enum logic [1:0] {
        PH0 = 2'd0,
        PH1 = 2'd1,
        PH2 = 2'd2,
        PH3 = 2'd3
    } phase_e;

    phase_e        phase_q, phase_d;
    logic [23:0]   residual_q, residual_d;
    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [31:0]   tdata_q, tdata_d;
    logic          tlast_q, tlast_d;
    logic          tuser_q, tuser_d;
    logic          tvalid_q, tvalid_d;
    logic          sync_err_q, sync_err_d;

    logic          accept_s;
    logic          at_origin_s;
    logic          resync_s;
    logic          load_s;
    logic [31:0]   word_s;

    // A PH0 pixel never produces a word, so it can always be taken.
    assign in_ready    = periph_resetn &&
                         ((phase_q == PH0) || !tvalid_q || out_stream_tready);
    assign accept_s    = in_valid && in_ready;
    assign at_origin_s = (x_q == '0) && (y_q == '0);
    assign resync_s    = in_sof && !at_origin_s;

    // Phase sequencing and byte packing of the accepted pixel into a word.
    always_comb begin
        phase_d    = phase_q;
        residual_d = residual_q;
        load_s     = 1'b0;
        word_s     = 32'd0;
        if (accept_s) begin
            if (resync_s) begin
                phase_d    = PH1;
                residual_d = in_pixel;
            end else begin
                case (phase_q)
                    PH0: begin
                        residual_d = in_pixel;
                        phase_d    = PH1;
                    end
                    PH1: begin
                        word_s     = {in_pixel[7:0], residual_q[23:0]};
                        residual_d = {8'd0, in_pixel[23:8]};
                        phase_d    = PH2;
                        load_s     = 1'b1;
                    end
                    PH2: begin
                        word_s     = {in_pixel[15:0], residual_q[15:0]};
                        residual_d = {16'd0, in_pixel[23:16]};
                        phase_d    = PH3;
                        load_s     = 1'b1;
                    end
                    PH3: begin
                        word_s     = {in_pixel[23:0], residual_q[7:0]};
                        residual_d = 24'd0;
                        phase_d    = PH0;
                        load_s     = 1'b1;
                    end
                    default: begin
                        residual_d = 24'd0;
                        phase_d    = PH0;
                    end
                endcase
            end
        end else begin
            phase_d    = phase_q;
            residual_d = residual_q;
        end
    end

    // Frame position; a resync pixel becomes pixel 0 so the next one is x=1.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept_s) begin
            if (resync_s) begin
                x_d = X_ONE;
                y_d = '0;
            end else if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + Y_ONE;
                end
            end else begin
                x_d = x_q + X_ONE;
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // Single-entry output register; load and drain may coincide.
    always_comb begin
        tdata_d  = tdata_q;
        tlast_d  = tlast_q;
        tuser_d  = tuser_q;
        tvalid_d = tvalid_q;
        if (load_s) begin
            tdata_d  = word_s;
            tlast_d  = (x_q == X_LAST);
            tuser_d  = (x_q == X_ONE) && (y_q == '0);
            tvalid_d = 1'b1;
        end else if (out_stream_tready) begin
            tvalid_d = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end
    end

    // Sticky marker of a start-of-frame seen away from the frame origin.
    always_comb begin
        sync_err_d = sync_err_q;
        if (accept_s && resync_s) begin
            sync_err_d = 1'b1;
        end else begin
            sync_err_d = sync_err_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge out_stream_aclk) begin
        if (!periph_resetn) begin
            phase_q    <= PH0;
            residual_q <= 24'd0;
            x_q        <= '0;
            y_q        <= '0;
            tdata_q    <= 32'd0;
            tlast_q    <= 1'b0;
            tuser_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            residual_q <= residual_d;
            x_q        <= x_d;
            y_q        <= y_d;
            tdata_q    <= tdata_d;
            tlast_q    <= tlast_d;
            tuser_q    <= tuser_d;
            tvalid_q   <= tvalid_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tvalid = tvalid_q;
    assign sync_err          = sync_err_q;

endmodule

// File: tb/tb_pixel_packer.sv
// Scoreboard bench for pixel_packer: a byte-queue reference packer predicts
// each word and its flags; words are compared as the DUT hands them off.
module tb_pixel_packer;

    localparam int XP  = 16;
    localparam int YP  = 4;
    localparam int WPL = XP * 3 / 4;

    logic        clk = 1'b0;
    logic        periph_resetn;
    logic [23:0] in_pixel;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast;
    logic        out_stream_tuser;
    logic        out_stream_tvalid;
    logic        out_stream_tready;
    logic        sync_err;

    always #5 clk = ~clk;

    pixel_packer #(.X_PIXELS(XP), .Y_LINES(YP)) dut (
        .out_stream_aclk   (clk),
        .periph_resetn     (periph_resetn),
        .in_pixel          (in_pixel),
        .in_sof            (in_sof),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .out_stream_tdata  (out_stream_tdata),
        .out_stream_tkeep  (out_stream_tkeep),
        .out_stream_tlast  (out_stream_tlast),
        .out_stream_tuser  (out_stream_tuser),
        .out_stream_tvalid (out_stream_tvalid),
        .out_stream_tready (out_stream_tready),
        .sync_err          (sync_err)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [7:0]  bq[$];
    logic [33:0] exp_q[$];
    logic [33:0] seen[$];
    int          mx = 0;
    int          my = 0;
    bit          sync_exp = 1'b0;
    bit          exp_valid = 1'b0;
    bit          pushed;
    bit          prev_stall = 1'b0;
    bit          after_rst = 1'b0;
    logic [33:0] prev_out;
    int          ready_low = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference packer: bytes R,G,B appended per pixel, every 4 bytes form a word.
    task automatic model_accept(input logic [23:0] px, input bit sof);
        logic [31:0] w;
        if (sof && !(mx == 0 && my == 0)) begin
            bq.delete();
            mx = 0;
            my = 0;
            sync_exp = 1'b1;
        end
        bq.push_back(px[7:0]);
        bq.push_back(px[15:8]);
        bq.push_back(px[23:16]);
        if (bq.size() >= 4) begin
            w = {bq[3], bq[2], bq[1], bq[0]};
            repeat (4) void'(bq.pop_front());
            exp_q.push_back({1'(mx == 1 && my == 0), 1'(mx == XP - 1), w});
            pushed = 1'b1;
        end
        mx++;
        if (mx == XP) begin
            mx = 0;
            my++;
            if (my == YP) my = 0;
        end
    endtask

    task automatic cycle(input bit v, input logic [23:0] px, input bit sof, input bit rdy, input bit rst);
        logic [33:0] cur;
        logic [33:0] e;
        bit          exp_rdy;
        @(negedge clk);
        periph_resetn     = !rst;
        in_valid          = v;
        in_pixel          = px;
        in_sof            = sof;
        out_stream_tready = rdy;
        #1;
        cur = {out_stream_tuser, out_stream_tlast, out_stream_tdata};
        exp_rdy = !rst && (bq.size() == 0 || !exp_valid || rdy);
        check_val("in_ready", in_ready, exp_rdy);
        check_val("tvalid", out_stream_tvalid, exp_valid);
        check_val("sync_err", sync_err, sync_exp);
        check_val("tkeep", out_stream_tkeep, 4'hF);
        if (prev_stall) check_val("stall_hold", cur, prev_out);
        if (after_rst) begin
            check_val("rst_tdata", out_stream_tdata, 32'd0);
            after_rst = 1'b0;
        end
        if (!in_ready) ready_low++;
        if (rst) begin
            bq.delete();
            exp_q.delete();
            mx = 0;
            my = 0;
            sync_exp   = 1'b0;
            exp_valid  = 1'b0;
            prev_stall = 1'b0;
            after_rst  = 1'b1;
        end else begin
            pushed = 1'b0;
            if (exp_valid && rdy && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_val("word", cur, e);
                seen.push_back(cur);
            end
            prev_stall = exp_valid && !rdy;
            prev_out   = cur;
            if (v && in_ready) model_accept(px, sof);
            if (pushed) exp_valid = 1'b1;
            else if (rdy) exp_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && (exp_valid || exp_q.size() > 0); i++)
            cycle(1'b0, 24'd0, 1'b0, 1'b1, 1'b0);
        check_val("drain", exp_q.size(), 0);
    endtask

    task automatic goto_pos(input int tx, input int ty);
        for (int i = 0; i < 4000 && !(mx == tx && my == ty); i++)
            cycle(1'b1, 24'($urandom), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check_val("goto_x", mx, tx);
        check_val("goto_y", my, ty);
    endtask

    initial begin
        logic [23:0] s_px;
        logic [23:0] n_px;
        int          n_last;
        int          n_user;

        periph_resetn     = 1'b0;
        in_valid          = 1'b0;
        in_pixel          = 24'd0;
        in_sof            = 1'b0;
        out_stream_tready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_val("rst_tvalid", out_stream_tvalid, 1'b0);
        check_val("rst_tdata", out_stream_tdata, 32'd0);
        check_val("rst_tlast", out_stream_tlast, 1'b0);
        check_val("rst_tuser", out_stream_tuser, 1'b0);
        check_val("rst_sync_err", sync_err, 1'b0);
        check_val("rst_in_ready", in_ready, 1'b0);

        // Single group with known words
        cycle(1'b1, 24'h030201, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 24'h060504, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 24'h090807, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 24'h0C0B0A, 1'b0, 1'b1, 1'b0);
        drain();
        check_val("grp_count", seen.size(), 3);
        check_val("grp_w0", seen[0], {2'b10, 32'h04030201});
        check_val("grp_w1", seen[1], {2'b00, 32'h08070605});
        check_val("grp_w2", seen[2], {2'b00, 32'h0C0B0A09});

        // Two full frames at full rate
        goto_pos(0, 0);
        drain();
        seen.delete();
        ready_low = 0;
        for (int i = 0; i < 2 * XP * YP; i++)
            cycle(1'b1, 24'($urandom), 1'(mx == 0 && my == 0), 1'b1, 1'b0);
        check_val("full_ready_low", ready_low, 0);
        drain();
        n_last = 0;
        n_user = 0;
        foreach (seen[i]) begin
            if (seen[i][32]) n_last++;
            if (seen[i][33]) n_user++;
        end
        check_val("full_words", seen.size(), 2 * WPL * YP);
        check_val("full_tlast", n_last, 2 * YP);
        check_val("full_tuser", n_user, 2);
        check_val("full_f2_tuser", seen[WPL * YP][33], 1'b1);
        check_val("full_l0_tlast", seen[WPL - 1][32], 1'b1);

        // Random valid and ready across two frames
        for (int i = 0; i < 4 * XP * YP; i++)
            cycle(1'($urandom_range(0, 1)), 24'($urandom), 1'(mx == 0 && my == 0),
                  1'($urandom_range(0, 1)), 1'b0);
        drain();

        // Start-of-frame marker at x=10, line 3
        goto_pos(10, 3);
        drain();
        seen.delete();
        s_px = 24'($urandom);
        n_px = 24'($urandom);
        cycle(1'b1, s_px, 1'b1, 1'b1, 1'b0);
        check_val("sof_newx", mx, 1);
        cycle(1'b1, n_px, 1'b0, 1'b1, 1'b0);
        goto_pos(0, 1);
        drain();
        check_val("sof_word", seen[0], {2'b10, n_px[7:0], s_px});
        check_val("sof_tlast", seen[WPL - 1][32], 1'b1);
        check_val("sof_sticky", sync_err, 1'b1);

        // Reset while a word is stalled mid-line
        for (int i = 0; i < 20 && !(exp_valid && bq.size() != 0); i++)
            cycle(1'b1, 24'($urandom), 1'b0, 1'b0, 1'b0);
        check_val("stall_setup", exp_valid, 1'b1);
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 24'd0, 1'b0, 1'b0, 1'b0);
        seen.delete();
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 24'($urandom), 1'b0, 1'b1, 1'b0);
        drain();
        check_val("post_rst_tuser", seen[0][33], 1'b1);
        check_val("post_rst_sync", sync_err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
